// File: rtl/router_pkg.sv
// Shared types and constants for the 1x3 router packet-reception controller.
package router_pkg;

    localparam int unsigned ADDR_W    = 2;
    localparam int unsigned NUM_PORTS = 3;

    localparam logic [ADDR_W-1:0] INVALID_ADDR = 2'b11;
    localparam logic [ADDR_W-1:0] PORT_0       = 2'd0;
    localparam logic [ADDR_W-1:0] PORT_1       = 2'd1;
    localparam logic [ADDR_W-1:0] PORT_2       = 2'd2;

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        LOAD_PARITY        = 3'd3,
        FIFO_FULL_STATE    = 3'd4,
        LOAD_AFTER_FULL    = 3'd5,
        WAIT_TILL_EMPTY    = 3'd6,
        CHECK_PARITY_ERROR = 3'd7
    } state_e;

    // Picks the per-port flag addressed by idx; the invalid address selects nothing.
    function automatic logic port_sel(input logic [NUM_PORTS-1:0] vec,
                                      input logic [ADDR_W-1:0]    idx);
        logic sel;
        sel = 1'b0;
        case (idx)
            PORT_0:  sel = vec[0];
            PORT_1:  sel = vec[1];
            PORT_2:  sel = vec[2];
            default: sel = 1'b0;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/router_fsm.sv
// Packet-reception controller: header decode, payload load, full stall and
// parity sequencing for the 1x3 router, with per-FIFO soft-reset abort.
module router_fsm
    import router_pkg::*;
(
    input  logic              clock,
    input  logic              resetn,
    input  logic              pkt_valid,
    input  logic [ADDR_W-1:0] data_in,
    input  logic              fifo_full,
    input  logic              fifo_empty_0,
    input  logic              fifo_empty_1,
    input  logic              fifo_empty_2,
    input  logic              soft_reset_0,
    input  logic              soft_reset_1,
    input  logic              soft_reset_2,
    input  logic              parity_done,
    input  logic              low_pkt_valid,
    output logic              detect_add,
    output logic              lfd_state,
    output logic              ld_state,
    output logic              laf_state,
    output logic              full_state,
    output logic              write_enb_reg,
    output logic              rst_int_reg,
    output logic              busy
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [NUM_PORTS-1:0] empty_vec;
    logic [NUM_PORTS-1:0] soft_vec;
    logic                empty_live;
    logic                empty_latched;
    logic                soft_hit;

    assign empty_vec     = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
    assign soft_vec      = {soft_reset_2, soft_reset_1, soft_reset_0};
    assign empty_live    = port_sel(empty_vec, data_in);
    assign empty_latched = port_sel(empty_vec, addr_q);
    assign soft_hit      = port_sel(soft_vec, addr_q);

    // State register and destination address latch.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= DECODE_ADDRESS;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    // Next-state logic; a soft reset of the targeted FIFO aborts any packet.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;

        if (state_q == DECODE_ADDRESS && pkt_valid) begin
            addr_d = data_in;
        end

        case (state_q)
            DECODE_ADDRESS: begin
                if (pkt_valid && data_in != INVALID_ADDR) begin
                    state_d = empty_live ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                end
            end
            LOAD_FIRST_DATA: state_d = LOAD_DATA;
            LOAD_DATA: begin
                if (fifo_full) begin
                    state_d = FIFO_FULL_STATE;
                end else if (!pkt_valid) begin
                    state_d = LOAD_PARITY;
                end
            end
            FIFO_FULL_STATE: begin
                if (!fifo_full) begin
                    state_d = LOAD_AFTER_FULL;
                end
            end
            LOAD_AFTER_FULL: begin
                if (parity_done) begin
                    state_d = DECODE_ADDRESS;
                end else if (low_pkt_valid) begin
                    state_d = LOAD_PARITY;
                end else begin
                    state_d = LOAD_DATA;
                end
            end
            LOAD_PARITY: state_d = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: begin
                state_d = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            end
            WAIT_TILL_EMPTY: begin
                if (empty_latched) begin
                    state_d = LOAD_FIRST_DATA;
                end
            end
            default: state_d = DECODE_ADDRESS;
        endcase

        if (state_q != DECODE_ADDRESS && soft_hit) begin
            state_d = DECODE_ADDRESS;
        end
    end

    // Moore output decode from the state register only.
    always_comb begin
        detect_add    = 1'b0;
        lfd_state     = 1'b0;
        ld_state      = 1'b0;
        laf_state     = 1'b0;
        full_state    = 1'b0;
        write_enb_reg = 1'b0;
        rst_int_reg   = 1'b0;
        busy          = 1'b1;
        case (state_q)
            DECODE_ADDRESS: begin
                detect_add = 1'b1;
                busy       = 1'b0;
            end
            LOAD_FIRST_DATA: lfd_state = 1'b1;
            LOAD_DATA: begin
                ld_state      = 1'b1;
                write_enb_reg = 1'b1;
                busy          = 1'b0;
            end
            LOAD_PARITY: write_enb_reg = 1'b1;
            FIFO_FULL_STATE: full_state = 1'b1;
            LOAD_AFTER_FULL: begin
                laf_state     = 1'b1;
                write_enb_reg = 1'b1;
            end
            CHECK_PARITY_ERROR: rst_int_reg = 1'b1;
            WAIT_TILL_EMPTY: ;
            default: ;
        endcase
    end

endmodule
